shiftreg_deser: RTL and testbench
=================================

Name: shiftreg_deser

Overview:
- Serial-to-parallel receiver; the receive end of the serial stream produced by `shiftreg_op` on `shift_out_right` (LSB-first) or `shift_out_left` (MSB-first).
- Collects N qualified bits after a start strobe, then presents the assembled word on `q` with a one-cycle `data_valid` pulse.
- Sits between a serial link and any parallel consumer; pairs with `shiftreg_op` in loopback benches.

Parameters:
- N, 4, word width in bits; legal range N >= 2.

Ports:
- enable  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin a new frame; also aborts a frame in progress.
- dir  input  1  bit order, sampled with start: 0 = LSB-first (right-shift source), 1 = MSB-first (left-shift source).
- bit_valid  input  1  `serial_in` is a valid data bit this cycle.
- serial_in  input  1  serial data bit.
- q  output  N  last completed word; held until the next completion.
- data_valid  output  1  one-cycle pulse: `q` was updated on this edge.
- busy  output  1  high while a frame is in progress (RECV or PARITY).
- abort  output  1  one-cycle pulse: a frame in progress was restarted by `start`.

Behaviour:
- Reset (reset_n = 0 at an edge):
  - Values: state = IDLE; q = 0; shift register = 0; bit count = 0; data_valid = abort = busy = 0.
  - Priority: reset overrides all other inputs, including mid-frame; a partial word is discarded and q is not updated.
- State IDLE:
  - bit_valid and serial_in are ignored.
  - start = 1 -> RECV; latch dir; count = 0; shift register = 0.
- State RECV:
  - start = 1: restart. count = 0, shift register = 0, re-latch dir, abort = 1 for one cycle. Any bit presented that cycle is discarded. Start has priority over bit_valid.
  - bit_valid = 1 with start = 0:
    - LSB-first: sreg <= {serial_in, sreg[N-1:1]}.
    - MSB-first: sreg <= {sreg[N-2:0], serial_in}.
    - count increments.
  - bit_valid = 0: hold; gaps of any length are allowed.
  - Completion: on the edge that samples bit N (count = N-1 with bit_valid = 1):
    - q <= assembled word; data_valid = 1 on the next cycle.
    - Next state IDLE (or PARITY if the optional feature is enabled).
- Latency: q and data_valid become visible one cycle after the edge that sampled the last bit.
- Back-to-back frames: start may be asserted in the cycle data_valid is high; it is accepted because the state is already IDLE. No dead cycle is required.
- busy = 1 iff state is RECV or PARITY; registered, so it rises the cycle after start is accepted.
- data_valid and abort are never high in the same cycle.
- Counter width is $clog2(N+1); count never exceeds N-1.
- dir changes outside a start cycle have no effect.

Optional Feature:
- Macro: SHIFTREG_DESER_PARITY_EN.
- Defined:
  - After bit N, the FSM enters PARITY and waits for one more bit_valid cycle carrying an even-parity bit (XOR of the N data bits and the parity bit must be 0).
  - On that edge: q updates, data_valid pulses, and the added output parity_err (1 bit, reset 0) is set to the check result. parity_err is valid only while data_valid = 1 and reads 0 otherwise.
  - start in PARITY behaves as in RECV (abort).
- Undefined: there is no PARITY state and no parity_err port; completion occurs on bit N.

Test Plan (N = 4):
- Reset, then start with dir = 0; bits 0,1,0,1 with bit_valid = 1 on consecutive cycles -> q = 4'b1010, data_valid high for exactly one cycle, busy low afterwards.
- start with dir = 1; bits 1,0,1,0 with two idle bit_valid = 0 cycles between bit 2 and bit 3 -> q = 4'b1010, busy high throughout the gap, no early data_valid.
- Frame with dir = 0 after 2 bits, then assert start with dir = 1 and send 1,1,0,0 -> abort pulses once, q = 4'b1100, and the earlier bits have no influence.
- Complete a 4'b0110 frame, then pull reset_n low after 2 bits of the next frame -> q = 0, busy = 0, no data_valid; a subsequent full frame 1,1,1,1 gives q = 4'b1111.
- Back-to-back frames: start in the data_valid cycle of frame 1 (dir = 0, bits 1,0,0,0 -> q = 4'b0001), then frame 2 (dir = 0, bits 0,0,0,1 -> q = 4'b1000) -> two data_valid pulses exactly 5 cycles apart.
- Loopback with `shiftreg_op`: load 4'b1010, shift right 4 times, feed `shift_out_right` into this block with dir = 0 -> q = 4'b1010. With SHIFTREG_DESER_PARITY_EN, send data 1,0,1,1 then parity 0 -> parity_err = 1; parity 1 -> parity_err = 0.

Source files
------------

// File: rtl/shiftreg_deser_if.sv
// Bus bundle for shiftreg_deser: frame control, serial input and parallel result.
// The parity_err signal exists only when SHIFTREG_DESER_PARITY_EN is defined.
interface shiftreg_deser_if #(
  parameter int N = 4
);
  logic         start;
  logic         dir;
  logic         bit_valid;
  logic         serial_in;
  logic [N-1:0] q;
  logic         data_valid;
  logic         busy;
  logic         abort;
`ifdef SHIFTREG_DESER_PARITY_EN
  logic         parity_err;

  modport master (
    output start, dir, bit_valid, serial_in,
    input  q, data_valid, busy, abort, parity_err
  );

  modport slave (
    input  start, dir, bit_valid, serial_in,
    output q, data_valid, busy, abort, parity_err
  );
`else
  modport master (
    output start, dir, bit_valid, serial_in,
    input  q, data_valid, busy, abort
  );

  modport slave (
    input  start, dir, bit_valid, serial_in,
    output q, data_valid, busy, abort
  );
`endif
endinterface

// File: rtl/shiftreg_deser.sv
// Serial-to-parallel receiver: collects N qualified bits after start, LSB- or MSB-first.
// Optional even-parity check after the data bits when SHIFTREG_DESER_PARITY_EN is defined.
module shiftreg_deser #(
  parameter int N = 4
) (
  input logic              enable,
  input logic              reset_n,
  shiftreg_deser_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PARITY
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  count_q, count_d;
  logic           dir_q, dir_d;
  logic [N-1:0]   q_q, q_d;
  logic           data_valid_q, data_valid_d;
  logic           abort_q, abort_d;
`ifdef SHIFTREG_DESER_PARITY_EN
  logic           parity_err_q, parity_err_d;
`endif

  // Start always wins over a data bit; in a frame it restarts and flags abort.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    count_d      = count_q;
    dir_d        = dir_q;
    q_d          = q_q;
    data_valid_d = 1'b0;
    abort_d      = 1'b0;
`ifdef SHIFTREG_DESER_PARITY_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RECV;
          dir_d   = bus.dir;
          count_d = '0;
          sreg_d  = '0;
        end
      end
      RECV: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          count_d = '0;
          sreg_d  = '0;
          abort_d = 1'b1;
        end else if (bus.bit_valid) begin
          if (dir_q)
            sreg_d = {sreg_q[N-2:0], bus.serial_in};
          else
            sreg_d = {bus.serial_in, sreg_q[N-1:1]};
          if (count_q == LAST) begin
            count_d = '0;
`ifdef SHIFTREG_DESER_PARITY_EN
            state_d = PARITY;
`else
            q_d          = sreg_d;
            data_valid_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
`ifdef SHIFTREG_DESER_PARITY_EN
      PARITY: begin
        if (bus.start) begin
          state_d = RECV;
          dir_d   = bus.dir;
          count_d = '0;
          sreg_d  = '0;
          abort_d = 1'b1;
        end else if (bus.bit_valid) begin
          q_d          = sreg_q;
          data_valid_d = 1'b1;
          parity_err_d = ^{sreg_q, bus.serial_in};
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge enable) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      q_q          <= '0;
      data_valid_q <= 1'b0;
      abort_q      <= 1'b0;
`ifdef SHIFTREG_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      q_q          <= q_d;
      data_valid_q <= data_valid_d;
      abort_q      <= abort_d;
`ifdef SHIFTREG_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.q          = q_q;
  assign bus.data_valid = data_valid_q;
  assign bus.abort      = abort_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef SHIFTREG_DESER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_shiftreg_deser.sv
// Bench for shiftreg_deser (N = 4): directed vector table, loopback sequence and
// random traffic against a queue-based frame model; parity sequence when SHIFTREG_DESER_PARITY_EN.
module tb_shiftreg_deser;

  localparam int N = 4;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       dir;
    logic       bv;
    logic       si;
    logic [3:0] exp_q;
    logic       exp_dv;
    logic       exp_busy;
    logic       exp_abort;
  } vec_t;

  logic enable;
  logic reset_n;
  int   vectors;
  int   miscompares;
  vec_t vecs[$];

  shiftreg_deser_if #(.N(N)) bus();

  shiftreg_deser #(.N(N)) dut (
    .enable  (enable),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    enable = 1'b0;
    forever #5 enable = ~enable;
  end

  // Frame model: a bit list since the last start, turned into a word when full.
  bit         m_in_frame;
  bit         m_dir;
  bit         m_bits[$];
  logic [3:0] m_q;
  bit         m_dv;
  bit         m_abort;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic d,
                                input logic v, input logic i);
    reset_n       = r;
    bus.start     = s;
    bus.dir       = d;
    bus.bit_valid = v;
    bus.serial_in = i;
    @(posedge enable);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic d, input logic v,
                     input logic i, input logic [3:0] q, input logic dv,
                     input logic busy, input logic ab);
    vec_t t;
    t.rst_n = r; t.start = s; t.dir = d; t.bv = v; t.si = i;
    t.exp_q = q; t.exp_dv = dv; t.exp_busy = busy; t.exp_abort = ab;
    vecs.push_back(t);
  endtask

  task automatic model_step(input logic r, input logic s, input logic d,
                            input logic v, input logic i);
    logic [3:0] w;
    m_dv    = 0;
    m_abort = 0;
    if (!r) begin
      m_in_frame = 0;
      m_q        = '0;
      m_bits.delete();
    end else if (s) begin
      m_abort    = m_in_frame;
      m_in_frame = 1;
      m_dir      = d;
      m_bits.delete();
    end else if (m_in_frame && v) begin
      m_bits.push_back(i);
      if (m_bits.size() == N) begin
        w = '0;
        for (int k = 0; k < N; k++) begin
          if (m_dir) w[N-1-k] = m_bits[k];
          else       w[k]     = m_bits[k];
        end
        m_q        = w;
        m_dv       = 1;
        m_in_frame = 0;
      end
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] q, input logic dv,
                           input logic busy, input logic ab);
    check_output({tag, ".q"}, 8'(bus.q), 8'(q));
    check_output({tag, ".data_valid"}, 8'(bus.data_valid), 8'(dv));
    check_output({tag, ".busy"}, 8'(bus.busy), 8'(busy));
    check_output({tag, ".abort"}, 8'(bus.abort), 8'(ab));
  endtask

  initial begin
    logic [3:0] sr;
    logic       r, s, d, v, i;
    vectors     = 0;
    miscompares = 0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SHIFTREG_DESER_PARITY_EN
    // Data 1,0,1,1 LSB-first gives 4'b1101 with odd weight, so parity 0 is an error.
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(1, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(1, 0, 0, 1, 1);
    check_output("par_wait.dv", 8'(bus.data_valid), 8'h0);
    check_output("par_wait.busy", 8'(bus.busy), 8'h1);
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("par0.q", 8'(bus.q), 8'hd);
    check_output("par0.dv", 8'(bus.data_valid), 8'h1);
    check_output("par0.err", 8'(bus.parity_err), 8'h1);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("par0.err_clear", 8'(bus.parity_err), 8'h0);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(1, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(1, 0, 0, 1, 1);
    check_output("par1.q", 8'(bus.q), 8'hd);
    check_output("par1.dv", 8'(bus.data_valid), 8'h1);
    check_output("par1.err", 8'(bus.parity_err), 8'h0);
`else
    // Directed frames: rst_n, start, dir, bit_valid, serial_in -> q, dv, busy, abort
    add(0,0,0,0,0, 4'h0,0,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0);
    add(1,0,0,1,0, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'h0,0,1,0);
    add(1,0,0,1,0, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'ha,1,0,0);
    add(1,0,0,0,0, 4'ha,0,0,0);
    add(1,0,0,1,1, 4'ha,0,0,0);
    add(1,1,1,0,0, 4'ha,0,1,0);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,0,0,1,0, 4'ha,0,1,0);
    add(1,0,0,0,0, 4'ha,0,1,0);
    add(1,0,0,0,1, 4'ha,0,1,0);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,0,0,1,0, 4'ha,1,0,0);
    add(1,1,0,0,0, 4'ha,0,1,0);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,1,1,1,1, 4'ha,0,1,1);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,0,0,1,1, 4'ha,0,1,0);
    add(1,0,0,1,0, 4'ha,0,1,0);
    add(1,0,0,1,0, 4'hc,1,0,0);
    add(1,1,0,0,0, 4'hc,0,1,0);
    add(1,0,0,1,0, 4'hc,0,1,0);
    add(1,0,0,1,1, 4'hc,0,1,0);
    add(1,0,0,1,1, 4'hc,0,1,0);
    add(1,0,0,1,0, 4'h6,1,0,0);
    add(1,1,0,0,0, 4'h6,0,1,0);
    add(1,0,0,1,1, 4'h6,0,1,0);
    add(1,0,0,1,1, 4'h6,0,1,0);
    add(0,0,0,1,1, 4'h0,0,0,0);
    add(1,0,0,1,1, 4'h0,0,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'h0,0,1,0);
    add(1,0,0,1,1, 4'hf,1,0,0);
    add(1,1,0,0,0, 4'hf,0,1,0);
    add(1,0,0,1,1, 4'hf,0,1,0);
    add(1,0,0,1,0, 4'hf,0,1,0);
    add(1,0,0,1,0, 4'hf,0,1,0);
    add(1,0,0,1,0, 4'h1,1,0,0);
    add(1,1,0,0,0, 4'h1,0,1,0);
    add(1,0,0,1,0, 4'h1,0,1,0);
    add(1,0,0,1,0, 4'h1,0,1,0);
    add(1,0,0,1,0, 4'h1,0,1,0);
    add(1,0,0,1,1, 4'h8,1,0,0);
    add(1,0,0,0,0, 4'h8,0,0,0);

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].rst_n, vecs[k].start, vecs[k].dir, vecs[k].bv, vecs[k].si);
      check_all($sformatf("vec%0d", k), vecs[k].exp_q, vecs[k].exp_dv,
                vecs[k].exp_busy, vecs[k].exp_abort);
    end

    // Loopback: a right-shifting source presents its LSB each cycle.
    sr = 4'b1010;
    apply_stimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      apply_stimulus(1, 0, 0, 1, sr[0]);
      sr = sr >> 1;
    end
    check_all("loopback", 4'b1010, 1'b1, 1'b0, 1'b0);

    // Random traffic against the frame model.
    apply_stimulus(0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 11) == 0);
      d = 1'($urandom);
      v = 1'($urandom);
      i = 1'($urandom);
      model_step(r, s, d, v, i);
      apply_stimulus(r, s, d, v, i);
      check_all($sformatf("rand%0d", k), m_q, m_dv, m_in_frame, m_abort);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
